mor1kx_avalon_arbiter: RTL and testbench
========================================

// Module: mor1kx_avalon_arbiter
// PURPOSE
// - Shares one mor1kx Avalon bus bridge between the CPU instruction bus (ibus)
//   and the data bus (dbus).
// - Sits between the fetch/LSU cpu_* style ports and the single cpu-side port of
//   the Avalon bridge.
// - Grants one master at a time, holds the grant for a full single or burst
//   transaction, then re-arbitrates.
// PARAMETERS
// - OPTION_DBUS_PRIORITY  1  fixed-priority winner when both request: 1=dbus, 0=ibus
// PORTS
// - clk           in   1   clock; all state updates on rising edge
// - rst_n         in   1   reset, asynchronous, active-low
// - ibus_req_i    in   1   ibus request; held until ack/err
// - ibus_adr_i    in   32  ibus address
// - ibus_burst_i  in   1   ibus burst; deasserts when last beat starts
// - ibus_ack_o    out  1   ibus ack (one cycle per beat)
// - ibus_err_o    out  1   ibus error
// - ibus_dat_o    out  32  ibus read data
// - dbus_req_i    in   1   dbus request; held until ack/err
// - dbus_adr_i    in   32  dbus address
// - dbus_dat_i    in   32  dbus write data
// - dbus_bsel_i   in   4   dbus byte selects
// - dbus_we_i     in   1   dbus write enable
// - dbus_burst_i  in   1   dbus burst
// - dbus_ack_o    out  1   dbus ack
// - dbus_err_o    out  1   dbus error
// - dbus_dat_o    out  32  dbus read data
// - m_req_o       out  1   request to bridge
// - m_adr_o       out  32  address to bridge
// - m_dat_o       out  32  write data to bridge
// - m_bsel_o      out  4   byte selects to bridge
// - m_we_o        out  1   write enable to bridge
// - m_burst_o     out  1   burst to bridge
// - m_ack_i       in   1   ack from bridge
// - m_err_i       in   1   error from bridge
// - m_dat_i       in   32  read data from bridge
// BEHAVIOUR
// - FSM, one-hot: IDLE, GNT_I, GNT_D. Reset: state=IDLE, last_gnt=ibus.
// - While rst_n low, all outputs are 0.
// - IDLE: if any req, register the winner and enter GNT_x next edge; m_req_o is
//   0 in IDLE, so request-to-bridge latency is 1 cycle.
// - GNT_x: m_* driven combinationally from the granted master; all other m_* = 0.
//   ibus path forces m_we_o=0, m_bsel_o=4'hf, m_dat_o=0.
// - GNT_x, m_req_o = granted req_i.
// - ack/err/dat: routed only to the granted master; the non-granted ack/err are 0.
//   dat_o passes m_dat_i to both masters unconditionally.
// - Completion: in GNT_x, (m_ack_i|m_err_i) & !x_burst_i returns to IDLE next edge.
// - Completion: ack with burst still high keeps the grant (more beats follow).
// - There is always one IDLE cycle between transactions, so back-to-back same
//   master costs 1 bubble.
// - Granted req dropped early: grant held until m_ack_i/m_err_i completes; that
//   ack is still forwarded.
// - A newly raised request from the other master while granted waits, never
//   preempts.
// - Simultaneous req in IDLE: winner per arbitration mode (see CONFIGURATION).
// - last_gnt updates on every IDLE->GNT transition.
// - Async reset mid-transaction: return to IDLE, outputs 0 immediately; the
//   bridge is reset by the same reset.
// CONFIGURATION
// - MOR1KX_AVALON_ARB_ROUND_ROBIN_EN defined: on simultaneous requests the
//   master not in last_gnt wins; a single requester always wins;
//   OPTION_DBUS_PRIORITY is ignored.
// - Not defined: fixed priority per OPTION_DBUS_PRIORITY; last_gnt is still
//   kept but does not affect arbitration.
// TESTING
// - dbus single write adr=0x100 dat=0xDEADBEEF bsel=4'hf -> m_req_o 1 cycle
//   after req, m_we_o=1, m_dat_o=0xDEADBEEF.
// - Same write, continued: dbus_ack_o on m_ack_i, IDLE on next edge.
// - ibus burst of 4 at 0x2000, burst_i dropping on beat 4 -> grant held across
//   all 4 acks, ibus_ack_o x4.
// - Same burst, continued: IDLE after 4th ack; dbus_ack_o stays 0 throughout.
// - Both req same cycle, default build -> dbus granted first, ibus next after
//   1 IDLE bubble.
// - Same stimulus, OPTION_DBUS_PRIORITY=0 -> ibus granted first.
// - ROUND_ROBIN_EN, both req continuously with single accesses -> grants
//   alternate D,I,D,I.
// - Same case continued: the first grant is dbus, because last_gnt=ibus after
//   reset.
// - m_err_i during dbus single read -> dbus_err_o=1 for 1 cycle, ibus_err_o=0,
//   return to IDLE.
// - rst_n low during GNT_I burst beat 2 -> m_req_o=0 and ibus_ack_o=0 at once.
// - After rst_n high with dbus req pending -> GNT_D after 1 cycle.

Source files
------------

// File: rtl/mor1kx_avalon_arbiter.sv
// rtl/mor1kx_avalon_arbiter.sv - ibus/dbus arbiter in front of one mor1kx Avalon bridge port
// MOR1KX_AVALON_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority.
module mor1kx_avalon_arbiter #(
  parameter int OPTION_DBUS_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ibus_req_i,
  input  logic [31:0] ibus_adr_i,
  input  logic        ibus_burst_i,
  output logic        ibus_ack_o,
  output logic        ibus_err_o,
  output logic [31:0] ibus_dat_o,
  input  logic        dbus_req_i,
  input  logic [31:0] dbus_adr_i,
  input  logic [31:0] dbus_dat_i,
  input  logic [3:0]  dbus_bsel_i,
  input  logic        dbus_we_i,
  input  logic        dbus_burst_i,
  output logic        dbus_ack_o,
  output logic        dbus_err_o,
  output logic [31:0] dbus_dat_o,
  output logic        m_req_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_bsel_o,
  output logic        m_we_o,
  output logic        m_burst_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  input  logic [31:0] m_dat_i
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    GNT_I = 3'b010,
    GNT_D = 3'b100
  } state_t;

  state_t state, state_next;
  logic   last_gnt, last_gnt_next;  // 1 = dbus held the last grant
  logic   pick_d;

  // Read data is shared; it is only forced low while the block is in reset.
  assign ibus_dat_o = rst_n ? m_dat_i : 32'h0;
  assign dbus_dat_o = rst_n ? m_dat_i : 32'h0;

  always_comb begin
`ifdef MOR1KX_AVALON_ARB_ROUND_ROBIN_EN
    pick_d = dbus_req_i & (!ibus_req_i | !last_gnt);
`else
    if (OPTION_DBUS_PRIORITY != 0)
      pick_d = dbus_req_i;
    else
      pick_d = dbus_req_i & !ibus_req_i;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_gnt <= 1'b0;
    end else begin
      state    <= state_next;
      last_gnt <= last_gnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    last_gnt_next = last_gnt;
    m_req_o       = 1'b0;
    m_adr_o       = 32'h0;
    m_dat_o       = 32'h0;
    m_bsel_o      = 4'h0;
    m_we_o        = 1'b0;
    m_burst_o     = 1'b0;
    ibus_ack_o    = 1'b0;
    ibus_err_o    = 1'b0;
    dbus_ack_o    = 1'b0;
    dbus_err_o    = 1'b0;
    case (state)
      IDLE: begin
        if (ibus_req_i | dbus_req_i) begin
          state_next    = pick_d ? GNT_D : GNT_I;
          last_gnt_next = pick_d;
        end
      end
      GNT_I: begin
        m_req_o    = ibus_req_i;
        m_adr_o    = ibus_adr_i;
        m_bsel_o   = 4'hf;
        m_burst_o  = ibus_burst_i;
        ibus_ack_o = m_ack_i;
        ibus_err_o = m_err_i;
        // An ack while burst is still high means more beats follow.
        if ((m_ack_i | m_err_i) & !ibus_burst_i)
          state_next = IDLE;
      end
      GNT_D: begin
        m_req_o    = dbus_req_i;
        m_adr_o    = dbus_adr_i;
        m_dat_o    = dbus_dat_i;
        m_bsel_o   = dbus_bsel_i;
        m_we_o     = dbus_we_i;
        m_burst_o  = dbus_burst_i;
        dbus_ack_o = m_ack_i;
        dbus_err_o = m_err_i;
        if ((m_ack_i | m_err_i) & !dbus_burst_i)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mor1kx_avalon_arbiter.sv
// tb/tb_mor1kx_avalon_arbiter.sv - self-checking bench for mor1kx_avalon_arbiter
module tb_mor1kx_avalon_arbiter;

  logic        clk, rst_n;
  logic        ibus_req_i, ibus_burst_i;
  logic [31:0] ibus_adr_i;
  logic        dbus_req_i, dbus_we_i, dbus_burst_i;
  logic [31:0] dbus_adr_i, dbus_dat_i;
  logic [3:0]  dbus_bsel_i;
  logic        m_ack_i, m_err_i;
  logic [31:0] m_dat_i;

  logic        ibus_ack_o, ibus_err_o, dbus_ack_o, dbus_err_o;
  logic [31:0] ibus_dat_o, dbus_dat_o, m_adr_o, m_dat_o;
  logic        m_req_o, m_we_o, m_burst_o;
  logic [3:0]  m_bsel_o;

  logic        p0_ibus_ack_o, p0_ibus_err_o, p0_dbus_ack_o, p0_dbus_err_o;
  logic [31:0] p0_ibus_dat_o, p0_dbus_dat_o, p0_m_adr_o, p0_m_dat_o;
  logic        p0_m_req_o, p0_m_we_o, p0_m_burst_o;
  logic [3:0]  p0_m_bsel_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] DADR = 32'h0000_0400;
  localparam logic [31:0] IADR = 32'h0000_3000;

  mor1kx_avalon_arbiter #(.OPTION_DBUS_PRIORITY(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ibus_req_i(ibus_req_i), .ibus_adr_i(ibus_adr_i), .ibus_burst_i(ibus_burst_i),
    .ibus_ack_o(ibus_ack_o), .ibus_err_o(ibus_err_o), .ibus_dat_o(ibus_dat_o),
    .dbus_req_i(dbus_req_i), .dbus_adr_i(dbus_adr_i), .dbus_dat_i(dbus_dat_i),
    .dbus_bsel_i(dbus_bsel_i), .dbus_we_i(dbus_we_i), .dbus_burst_i(dbus_burst_i),
    .dbus_ack_o(dbus_ack_o), .dbus_err_o(dbus_err_o), .dbus_dat_o(dbus_dat_o),
    .m_req_o(m_req_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_bsel_o(m_bsel_o),
    .m_we_o(m_we_o), .m_burst_o(m_burst_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_dat_i(m_dat_i)
  );

  // Second instance with ibus priority, only checked in the simultaneous-request case.
  mor1kx_avalon_arbiter #(.OPTION_DBUS_PRIORITY(0)) u_dut_ip (
    .clk(clk), .rst_n(rst_n),
    .ibus_req_i(ibus_req_i), .ibus_adr_i(ibus_adr_i), .ibus_burst_i(ibus_burst_i),
    .ibus_ack_o(p0_ibus_ack_o), .ibus_err_o(p0_ibus_err_o), .ibus_dat_o(p0_ibus_dat_o),
    .dbus_req_i(dbus_req_i), .dbus_adr_i(dbus_adr_i), .dbus_dat_i(dbus_dat_i),
    .dbus_bsel_i(dbus_bsel_i), .dbus_we_i(dbus_we_i), .dbus_burst_i(dbus_burst_i),
    .dbus_ack_o(p0_dbus_ack_o), .dbus_err_o(p0_dbus_err_o), .dbus_dat_o(p0_dbus_dat_o),
    .m_req_o(p0_m_req_o), .m_adr_o(p0_m_adr_o), .m_dat_o(p0_m_dat_o), .m_bsel_o(p0_m_bsel_o),
    .m_we_o(p0_m_we_o), .m_burst_o(p0_m_burst_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_dat_i(m_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model: who owns the bridge (0 none, 1 ibus, 2 dbus) and who owned it last.
  int owner = 0;
  int last_owner = 1;

  function automatic int winner(logic ireq, logic dreq, int last);
    if (ireq && !dreq) return 1;
    if (dreq && !ireq) return 2;
`ifdef MOR1KX_AVALON_ARB_ROUND_ROBIN_EN
    return (last == 2) ? 1 : 2;
`else
    return 2;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= 0;
      last_owner <= 1;
    end else if (owner == 0) begin
      if (ibus_req_i || dbus_req_i) begin
        owner      <= winner(ibus_req_i, dbus_req_i, last_owner);
        last_owner <= winner(ibus_req_i, dbus_req_i, last_owner);
      end
    end else if ((m_ack_i || m_err_i) && !((owner == 1) ? ibus_burst_i : dbus_burst_i)) begin
      owner <= 0;
    end
  end

  always @(negedge clk) begin
    logic [138:0] exp_v, act_v;
    logic i, d;
    i = (owner == 1);
    d = (owner == 2);
    if (!rst_n) begin
      exp_v = '0;
    end else begin
      exp_v = {i & m_ack_i, i & m_err_i, m_dat_i,
               d & m_ack_i, d & m_err_i, m_dat_i,
               i ? ibus_req_i : (d & dbus_req_i),
               i ? ibus_adr_i : (d ? dbus_adr_i : 32'h0),
               d ? dbus_dat_i : 32'h0,
               i ? 4'hf : (d ? dbus_bsel_i : 4'h0),
               d & dbus_we_i,
               i ? ibus_burst_i : (d & dbus_burst_i)};
    end
    act_v = {ibus_ack_o, ibus_err_o, ibus_dat_o, dbus_ack_o, dbus_err_o, dbus_dat_o,
             m_req_o, m_adr_o, m_dat_o, m_bsel_o, m_we_o, m_burst_o};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model_cycle t=%0t: got %h expected %h", $time, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ibus_req_i = 0; ibus_adr_i = 0; ibus_burst_i = 0;
    dbus_req_i = 0; dbus_adr_i = 0; dbus_dat_i = 0; dbus_bsel_i = 0;
    dbus_we_i = 0; dbus_burst_i = 0;
    m_ack_i = 0; m_err_i = 0; m_dat_i = 32'h1234_5678;
    #2;
    chk("reset_m_req", {31'h0, m_req_o}, 32'h0);
    chk("reset_ibus_dat", ibus_dat_o, 32'h0);
    chk("reset_m_bsel", {28'h0, m_bsel_o}, 32'h0);
    cyc(); cyc();
    rst_n = 1'b1;

    // dbus single write
    dbus_req_i = 1; dbus_adr_i = 32'h100; dbus_dat_i = 32'hDEAD_BEEF;
    dbus_bsel_i = 4'hf; dbus_we_i = 1;
    #1 chk("s1_idle_no_req", {31'h0, m_req_o}, 32'h0);
    cyc();
    chk("s1_m_req", {31'h0, m_req_o}, 32'h1);
    chk("s1_m_we", {31'h0, m_we_o}, 32'h1);
    chk("s1_m_dat", m_dat_o, 32'hDEAD_BEEF);
    chk("s1_m_adr", m_adr_o, 32'h100);
    m_ack_i = 1;
    #1 chk("s1_dbus_ack", {31'h0, dbus_ack_o}, 32'h1);
    cyc();
    m_ack_i = 0; dbus_req_i = 0; dbus_we_i = 0;
    #1 chk("s1_back_idle", {31'h0, m_req_o}, 32'h0);
    cyc();

    // ibus burst of 4
    ibus_req_i = 1; ibus_adr_i = 32'h2000; ibus_burst_i = 1;
    cyc();
    for (int k = 0; k < 4; k++) begin
      ibus_adr_i = 32'h2000 + 32'(4 * k);
      ibus_burst_i = (k < 3);
      m_dat_i = 32'hA000_0000 + 32'(k);
      m_ack_i = 1;
      #1;
      chk("s2_ibus_ack", {31'h0, ibus_ack_o}, 32'h1);
      chk("s2_dbus_ack_quiet", {31'h0, dbus_ack_o}, 32'h0);
      chk("s2_m_adr", m_adr_o, 32'h2000 + 32'(4 * k));
      chk("s2_ibus_dat", ibus_dat_o, 32'hA000_0000 + 32'(k));
      cyc();
    end
    m_ack_i = 0; ibus_req_i = 0; ibus_burst_i = 0;
    #1 chk("s2_back_idle", {31'h0, m_req_o}, 32'h0);
    cyc();

    // simultaneous requests
    ibus_req_i = 1; ibus_adr_i = IADR; dbus_req_i = 1; dbus_adr_i = DADR; dbus_bsel_i = 4'h3;
    cyc();
    chk("s3_first_grant", m_adr_o, DADR);
`ifdef MOR1KX_AVALON_ARB_ROUND_ROBIN_EN
    chk("s3_ip_first_grant", p0_m_adr_o, DADR);
`else
    chk("s3_ip_first_grant", p0_m_adr_o, IADR);
`endif
    chk("s3_ip_m_req", {31'h0, p0_m_req_o}, 32'h1);
    m_ack_i = 1;
    cyc();
    m_ack_i = 0; dbus_req_i = 0;
    #1 chk("s3_bubble", {31'h0, m_req_o}, 32'h0);
    cyc();
    chk("s3_second_grant", m_adr_o, IADR);
    chk("s3_second_bsel", {28'h0, m_bsel_o}, 32'hf);
    m_ack_i = 1;
    cyc();
    m_ack_i = 0; ibus_req_i = 0;
    cyc();

    // continuous requests from both masters
    ibus_req_i = 1; dbus_req_i = 1;
    for (int g = 0; g < 4; g++) begin
      int n;
      n = 0;
      while (!m_req_o && n < 6) begin
        cyc();
        n++;
      end
      chk("s4_grant_seen", {31'h0, m_req_o}, 32'h1);
`ifdef MOR1KX_AVALON_ARB_ROUND_ROBIN_EN
      chk("s4_grant_order", m_adr_o, (g % 2 == 0) ? DADR : IADR);
`else
      chk("s4_grant_order", m_adr_o, DADR);
`endif
      m_ack_i = 1;
      cyc();
      m_ack_i = 0;
    end
    ibus_req_i = 0; dbus_req_i = 0;
    cyc();

    // dbus read terminated by error
    dbus_req_i = 1; dbus_we_i = 0; dbus_adr_i = 32'h500; m_dat_i = 32'hCAFE_F00D;
    cyc();
    m_err_i = 1;
    #1;
    chk("s5_dbus_err", {31'h0, dbus_err_o}, 32'h1);
    chk("s5_ibus_err", {31'h0, ibus_err_o}, 32'h0);
    chk("s5_dbus_dat", dbus_dat_o, 32'hCAFE_F00D);
    cyc();
    m_err_i = 0; dbus_req_i = 0;
    #1;
    chk("s5_err_one_cycle", {31'h0, dbus_err_o}, 32'h0);
    chk("s5_back_idle", {31'h0, m_req_o}, 32'h0);
    cyc();

    // reset during ibus burst beat 2, then pending dbus request
    ibus_req_i = 1; ibus_adr_i = 32'h6000; ibus_burst_i = 1;
    cyc();
    m_ack_i = 1;
    cyc();
    ibus_adr_i = 32'h6004;
    #1 chk("s6_beat2_ack", {31'h0, ibus_ack_o}, 32'h1);
    rst_n = 0;
    #1;
    chk("s6_rst_m_req", {31'h0, m_req_o}, 32'h0);
    chk("s6_rst_ibus_ack", {31'h0, ibus_ack_o}, 32'h0);
    m_ack_i = 0; ibus_req_i = 0; ibus_burst_i = 0;
    dbus_req_i = 1; dbus_adr_i = 32'h700;
    cyc(); cyc();
    rst_n = 1;
    #1 chk("s6_post_rst_idle", {31'h0, m_req_o}, 32'h0);
    cyc();
    chk("s6_gnt_d_req", {31'h0, m_req_o}, 32'h1);
    chk("s6_gnt_d_adr", m_adr_o, 32'h700);
    m_ack_i = 1;
    cyc();
    m_ack_i = 0; dbus_req_i = 0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
